mc_ctrl: RTL
============

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning max wait cycles for mem_ready before bus error (legal 2..255).
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have inputs opCode 6 (instruction [31:26]), zero 1 (ALU zero flag), INT 1 (interrupt request), mem_ready 1 (memory access complete this cycle).
REQ-005 SHALL have 1-bit outputs PCWrite, IRWrite, IorD, MemRead, MemWrite, Mem2Reg, RegDst, RegWrite, ALUSrcA, bus_err and ill_op.
REQ-006 SHALL have 2-bit outputs ALUSrcB (00 rd2, 01 const 4, 10 imm, 11 imm*4), ALUop (00 add, 01 sub, 10 funct), PCSource (00 ALU, 01 ALUOut, 10 jump target, 11 entryPoint), and a 4-bit state output.

Function
REQ-007 SHALL be a multicycle Moore FSM: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, RWB, BRANCH, JUMP; all outputs are 0 unless listed for the state.
REQ-008 IDLE: all outputs 0; next state is FETCH unconditionally.
REQ-009 FETCH: MemRead=1, IorD=0, ALUSrcB=01; on mem_ready=1: IRWrite=1, PCWrite=1, PCSource=00, next DECODE; otherwise stay.
REQ-010 FETCH, first cycle (wait count 0) with INT=1: MemRead=0, PCWrite=1, PCSource=11, IRWrite=0, stay FETCH; INT has priority over mem_ready.
REQ-011 DECODE: ALUSrcB=11, ALUop=00; next by opCode: 000000->EXEC, 100011/101011->MEMADR, 000100->BRANCH, 000010->JUMP.
REQ-012 DECODE with any other opCode: ill_op=1 for that cycle, next FETCH (instruction is a no-op).
REQ-013 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUop=00; next MEMRD if opCode=100011, else MEMWR.
REQ-014 MEMRD: MemRead=1, IorD=1; on mem_ready next MEMWB. MEMWB: RegWrite=1, Mem2Reg=1, RegDst=0; next FETCH.
REQ-015 MEMWR: MemWrite=1, IorD=1; on mem_ready next FETCH.
REQ-016 EXEC: ALUSrcA=1, ALUSrcB=00, ALUop=10; next RWB. RWB: RegWrite=1, RegDst=1; next FETCH.
REQ-017 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUop=01, PCSource=01, PCWrite=zero (only Mealy output); next FETCH.
REQ-018 JUMP: PCWrite=1, PCSource=10; next FETCH.
REQ-019 Wait counter (8-bit) SHALL increment each cycle spent in FETCH, MEMRD or MEMWR with mem_ready=0, and SHALL clear on every state change.
REQ-020 When counter = TIMEOUT-1 and mem_ready=0: bus_err=1 for that cycle, next FETCH (no register write, no PC write); mem_ready=1 on that same cycle completes normally with no bus_err.
REQ-021 Instruction latencies with mem_ready always 1: R-type 4, lw 5, sw 4, beq 3, j 3 cycles.

Reset
REQ-022 rst=1 SHALL force state IDLE and clear wait counter immediately; all outputs 0 while rst=1, including mid-access (pending memory operation is abandoned).
REQ-023 First FETCH SHALL occur in the second clock after rst deasserts.

Configuration
REQ-024 With MC_CTRL_PERF_EN defined: 32-bit outputs cycle_cnt (increments every non-reset cycle) and instr_cnt (increments on entry to FETCH from MEMWB, MEMWR-complete, RWB, BRANCH, JUMP), both wrap at 2^32, reset to 0.
REQ-025 Without MC_CTRL_PERF_EN: ports and counters absent; all other behaviour identical.

Structure
REQ-026 Package mc_ctrl_pkg SHALL hold the state encoding, opcode constants, ALUSrcB/ALUop/PCSource encodings.
REQ-027 Wait counter SHALL be sub-module mc_wait_timer (clear, count-enable, terminal-count out).

Verification
REQ-028 rst pulse, mem_ready=1, opCode=000000 -> states IDLE,FETCH,DECODE,EXEC,RWB,FETCH; RegWrite=1 and RegDst=1 only in RWB.
REQ-029 opCode=100011, mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles, then MEMWB with Mem2Reg=1, bus_err never 1.
REQ-030 TIMEOUT=4, mem_ready=0 in MEMWR -> bus_err=1 on 4th MEMWR cycle, next state FETCH, RegWrite never 1.
REQ-031 opCode=000100, zero=1 then zero=0 -> PCWrite=1 with PCSource=01 in BRANCH first time, PCWrite=0 second time.
REQ-032 INT=1 and mem_ready=1 on first FETCH cycle -> PCSource=11, PCWrite=1, IRWrite=0, MemRead=0, state stays FETCH.
REQ-033 opCode=111111 -> ill_op=1 in DECODE for one cycle, next FETCH; rst asserted during MEMRD -> outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle controller: state codes, opcodes and
// datapath mux/ALU select values.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_RWB    = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM4 = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_ENTRY  = 2'b11;

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath/memory signal bundle; master drives instruction
// fields and memory status, slave (the controller) drives the control lines.
interface mc_ctrl_if;
    logic [5:0] opCode;
    logic       zero;
    logic       INT;
    logic       mem_ready;

    logic       PCWrite, IRWrite, IorD, MemRead, MemWrite, Mem2Reg;
    logic       RegDst, RegWrite, ALUSrcA, bus_err, ill_op;
    logic [1:0] ALUSrcB, ALUop, PCSource;
    logic [3:0] state;

    modport master (
        output opCode, zero, INT, mem_ready,
        input  PCWrite, IRWrite, IorD, MemRead, MemWrite, Mem2Reg,
               RegDst, RegWrite, ALUSrcA, bus_err, ill_op,
               ALUSrcB, ALUop, PCSource, state
    );

    modport slave (
        input  opCode, zero, INT, mem_ready,
        output PCWrite, IRWrite, IorD, MemRead, MemWrite, Mem2Reg,
               RegDst, RegWrite, ALUSrcA, bus_err, ill_op,
               ALUSrcB, ALUop, PCSource, state
    );
endinterface

// File: rtl/mc_wait_timer.sv
// Memory wait-cycle counter; clear wins over enable, tc flags TIMEOUT-1.
// Zero latency on tc/cnt (registered count, combinational compare); no backpressure.
module mc_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    output logic [7:0] cnt,
    output logic       tc
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      cnt <= 8'd0;
        else if (clr) cnt <= 8'd0;
        else if (en)  cnt <= cnt + 8'd1;
    end

    assign tc = (cnt == 8'(TIMEOUT - 1));
endmodule

// File: rtl/mc_ctrl.sv
// Multicycle CPU control FSM with memory-wait timeout; optional MC_CTRL_PERF_EN counters.
// Outputs valid in the cycle of the state; memory stalls via mem_ready, bus_err after TIMEOUT waits.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    mc_ctrl_if.slave    bus
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
`endif
);
    state_t     st, nxt;
    logic       tmr_clr, tmr_en, tmr_tc;
    logic [7:0] tmr_cnt;

    mc_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (tmr_clr),
        .en  (tmr_en),
        .cnt (tmr_cnt),
        .tc  (tmr_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) st <= S_IDLE;
        else     st <= nxt;
    end

    always_comb begin
        nxt          = st;
        tmr_clr      = 1'b0;
        tmr_en       = 1'b0;
        bus.PCWrite  = 1'b0;
        bus.IRWrite  = 1'b0;
        bus.IorD     = 1'b0;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.Mem2Reg  = 1'b0;
        bus.RegDst   = 1'b0;
        bus.RegWrite = 1'b0;
        bus.ALUSrcA  = 1'b0;
        bus.bus_err  = 1'b0;
        bus.ill_op   = 1'b0;
        bus.ALUSrcB  = SRCB_RD2;
        bus.ALUop    = ALU_ADD;
        bus.PCSource = PC_ALU;

        case (st)
            S_IDLE: nxt = S_FETCH;
            S_FETCH: begin
                bus.ALUSrcB = SRCB_FOUR;
                // An interrupt taken on the opening fetch cycle restarts the fetch at the entry point.
                if (bus.INT && (tmr_cnt == 8'd0)) begin
                    bus.PCWrite  = 1'b1;
                    bus.PCSource = PC_ENTRY;
                    tmr_clr      = 1'b1;
                end else begin
                    bus.MemRead = 1'b1;
                    if (bus.mem_ready) begin
                        bus.IRWrite = 1'b1;
                        bus.PCWrite = 1'b1;
                        nxt         = S_DECODE;
                    end else if (tmr_tc) begin
                        bus.bus_err = 1'b1;
                        tmr_clr     = 1'b1;
                    end else begin
                        tmr_en = 1'b1;
                    end
                end
            end
            S_DECODE: begin
                bus.ALUSrcB = SRCB_IMM4;
                if (bus.opCode == OP_RTYPE)       nxt = S_EXEC;
                else if (is_mem_op(bus.opCode))   nxt = S_MEMADR;
                else if (bus.opCode == OP_BEQ)    nxt = S_BRANCH;
                else if (bus.opCode == OP_J)      nxt = S_JUMP;
                else begin
                    bus.ill_op = 1'b1;
                    nxt        = S_FETCH;
                end
            end
            S_MEMADR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = SRCB_IMM;
                nxt         = (bus.opCode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD, S_MEMWR: begin
                bus.IorD     = 1'b1;
                bus.MemRead  = (st == S_MEMRD);
                bus.MemWrite = (st == S_MEMWR);
                if (bus.mem_ready) begin
                    nxt = (st == S_MEMRD) ? S_MEMWB : S_FETCH;
                end else if (tmr_tc) begin
                    bus.bus_err = 1'b1;
                    nxt         = S_FETCH;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            S_MEMWB: begin
                bus.RegWrite = 1'b1;
                bus.Mem2Reg  = 1'b1;
                nxt          = S_FETCH;
            end
            S_EXEC: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUop   = ALU_FUNCT;
                nxt         = S_RWB;
            end
            S_RWB: begin
                bus.RegWrite = 1'b1;
                bus.RegDst   = 1'b1;
                nxt          = S_FETCH;
            end
            S_BRANCH: begin
                bus.ALUSrcA  = 1'b1;
                bus.ALUop    = ALU_SUB;
                bus.PCSource = PC_ALUOUT;
                bus.PCWrite  = bus.zero;
                nxt          = S_FETCH;
            end
            S_JUMP: begin
                bus.PCWrite  = 1'b1;
                bus.PCSource = PC_JUMP;
                nxt          = S_FETCH;
            end
            default: nxt = S_IDLE;
        endcase

        if (nxt != st) tmr_clr = 1'b1;
    end

    assign bus.state = st;

`ifdef MC_CTRL_PERF_EN
    logic instr_done;
    assign instr_done = (nxt == S_FETCH) &&
                        ((st == S_MEMWB) || (st == S_RWB) || (st == S_BRANCH) ||
                         (st == S_JUMP)  || ((st == S_MEMWR) && bus.mem_ready));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt <= 32'd0;
            instr_cnt <= 32'd0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (instr_done) instr_cnt <= instr_cnt + 32'd1;
        end
    end
`endif
endmodule
